// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_ctrl_pkg: opcodes, control-word bit indices and sequencer states.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package cpu_ctrl_pkg;

    localparam int OP_NOP = 0;
    localparam int OP_LDA = 1;
    localparam int OP_ADD = 2;
    localparam int OP_SUB = 3;
    localparam int OP_STA = 4;
    localparam int OP_LDI = 5;
    localparam int OP_JMP = 6;
    localparam int OP_JC  = 7;
    localparam int OP_JZ  = 8;
    localparam int OP_OUT = 14;
    localparam int OP_HLT = 15;

    localparam int CTRL_HLT = 15;
    localparam int CTRL_MI  = 14;
    localparam int CTRL_RI  = 13;
    localparam int CTRL_RO  = 12;
    localparam int CTRL_IO  = 11;
    localparam int CTRL_II  = 10;
    localparam int CTRL_AI  = 9;
    localparam int CTRL_AO  = 8;
    localparam int CTRL_EO  = 7;
    localparam int CTRL_SU  = 6;
    localparam int CTRL_BI  = 5;
    localparam int CTRL_OI  = 4;
    localparam int CTRL_CE  = 3;
    localparam int CTRL_CO  = 2;
    localparam int CTRL_J   = 1;
    localparam int CTRL_FI  = 0;

    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/control_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | control_sequencer_if: step/instruction/flag inputs and control outputs.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface control_sequencer_if #(
    parameter int OPC_W  = 4,
    parameter int CTRL_W = 16
);
    logic [2:0]        Step;
    logic [OPC_W-1:0]  InstrIn;
    logic              FlagC;
    logic              FlagZ;
    logic              Start;
    logic [CTRL_W-1:0] Ctrl;
    logic              StepCounterReset;
    logic [OPC_W-1:0]  Opcode;
    logic              Halted;
    logic              Fault;

    modport master (
        output Step, InstrIn, FlagC, FlagZ, Start,
        input  Ctrl, StepCounterReset, Opcode, Halted, Fault
    );

    modport slave (
        input  Step, InstrIn, FlagC, FlagZ, Start,
        output Ctrl, StepCounterReset, Opcode, Halted, Fault
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ctrl_decode: combinational microcode ROM {opcode, step, flags} -> control. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPC_W  = 4,
    parameter int CTRL_W = 16
) (
    input  logic [OPC_W-1:0]  i_opcode,
    input  logic [2:0]        i_step,
    input  logic              i_flag_c,
    input  logic              i_flag_z,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_last_step,
    output logic              o_is_hlt,
    output logic              o_illegal
);

    logic [2:0] w_last;

    always_comb begin
        w_last = 3'd2;
        case (i_opcode)
            OPC_W'(OP_LDA), OPC_W'(OP_STA): w_last = 3'd3;
            OPC_W'(OP_ADD), OPC_W'(OP_SUB): w_last = 3'd4;
            default:                        w_last = 3'd2;
        endcase
    end

    always_comb begin
        o_ctrl = '0;
        case (i_step)
            3'd0: begin
                o_ctrl[CTRL_CO] = 1'b1;
                o_ctrl[CTRL_MI] = 1'b1;
            end
            3'd1: begin
                o_ctrl[CTRL_RO] = 1'b1;
                o_ctrl[CTRL_II] = 1'b1;
                o_ctrl[CTRL_CE] = 1'b1;
            end
            3'd2: begin
                case (i_opcode)
                    OPC_W'(OP_LDA), OPC_W'(OP_ADD), OPC_W'(OP_SUB), OPC_W'(OP_STA): begin
                        o_ctrl[CTRL_IO] = 1'b1;
                        o_ctrl[CTRL_MI] = 1'b1;
                    end
                    OPC_W'(OP_LDI): begin
                        o_ctrl[CTRL_IO] = 1'b1;
                        o_ctrl[CTRL_AI] = 1'b1;
                    end
                    OPC_W'(OP_JMP): begin
                        o_ctrl[CTRL_IO] = 1'b1;
                        o_ctrl[CTRL_J]  = 1'b1;
                    end
                    OPC_W'(OP_JC): begin
                        o_ctrl[CTRL_IO] = i_flag_c;
                        o_ctrl[CTRL_J]  = i_flag_c;
                    end
                    OPC_W'(OP_JZ): begin
                        o_ctrl[CTRL_IO] = i_flag_z;
                        o_ctrl[CTRL_J]  = i_flag_z;
                    end
                    OPC_W'(OP_OUT): begin
                        o_ctrl[CTRL_AO] = 1'b1;
                        o_ctrl[CTRL_OI] = 1'b1;
                    end
                    OPC_W'(OP_HLT): o_ctrl[CTRL_HLT] = 1'b1;
                    default: ;
                endcase
            end
            3'd3: begin
                case (i_opcode)
                    OPC_W'(OP_LDA): begin
                        o_ctrl[CTRL_RO] = 1'b1;
                        o_ctrl[CTRL_AI] = 1'b1;
                    end
                    OPC_W'(OP_ADD), OPC_W'(OP_SUB): begin
                        o_ctrl[CTRL_RO] = 1'b1;
                        o_ctrl[CTRL_BI] = 1'b1;
                    end
                    OPC_W'(OP_STA): begin
                        o_ctrl[CTRL_AO] = 1'b1;
                        o_ctrl[CTRL_RI] = 1'b1;
                    end
                    default: ;
                endcase
            end
            3'd4: begin
                if (i_opcode == OPC_W'(OP_ADD) || i_opcode == OPC_W'(OP_SUB)) begin
                    o_ctrl[CTRL_EO] = 1'b1;
                    o_ctrl[CTRL_AI] = 1'b1;
                    o_ctrl[CTRL_FI] = 1'b1;
                    o_ctrl[CTRL_SU] = (i_opcode == OPC_W'(OP_SUB));
                end
            end
            default: ;
        endcase
    end

    // Every opcode ends at step 2 or later, so steps 5-7 are always past the end.
    assign o_last_step = (i_step == w_last);
    assign o_illegal   = (i_step > w_last);
    assign o_is_hlt    = (i_opcode == OPC_W'(OP_HLT)) && (i_step == 3'd2);

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | control_sequencer: run/halt FSM, opcode latch and sticky fault for the CPU.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPC_W  = 4,
    parameter int CTRL_W = 16
) (
    input  wire logic               Clk,
    input  wire logic               RstN,
    control_sequencer_if.slave      bus
);

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [OPC_W-1:0]  r_opcode;
    logic              r_fault;
    logic [CTRL_W-1:0] w_dec_ctrl;
    logic [CTRL_W-1:0] w_ctrl;
    logic              w_last;
    logic              w_is_hlt;
    logic              w_illegal;
    logic              w_scr;

    ctrl_decode #(
        .OPC_W  (OPC_W),
        .CTRL_W (CTRL_W)
    ) u_decode (
        .i_opcode    (r_opcode),
        .i_step      (bus.Step),
        .i_flag_c    (bus.FlagC),
        .i_flag_z    (bus.FlagZ),
        .o_ctrl      (w_dec_ctrl),
        .o_last_step (w_last),
        .o_is_hlt    (w_is_hlt),
        .o_illegal   (w_illegal)
    );

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_SYNC: w_next = ST_RUN;
            ST_RUN:  if (!w_illegal && w_is_hlt) w_next = ST_HALT;
            ST_HALT: if (bus.Start) w_next = ST_RUN;
            default: w_next = ST_SYNC;
        endcase
    end

    // Outside a legal RUN step the step counter is held at 0 and nothing is gated.
    always_comb begin
        w_ctrl = '0;
        w_scr  = 1'b1;
        if (r_state == ST_RUN && !w_illegal) begin
            w_ctrl = w_dec_ctrl;
            w_scr  = w_last;
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_opcode <= '0;
            r_fault  <= 1'b0;
        end else begin
            if (r_state == ST_RUN && bus.Step == 3'd1) begin
                r_opcode <= bus.InstrIn;
            end
            if (r_state == ST_RUN && w_illegal) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign bus.Ctrl             = w_ctrl;
    assign bus.StepCounterReset = w_scr;
    assign bus.Opcode           = r_opcode;
    assign bus.Halted           = (r_state == ST_HALT);
    assign bus.Fault            = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_control_sequencer: vector table, corner sequences and random stimulus.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_control_sequencer;

    localparam logic [15:0] C_HLT = 16'h8000;
    localparam logic [15:0] C_MI  = 16'h4000;
    localparam logic [15:0] C_RI  = 16'h2000;
    localparam logic [15:0] C_RO  = 16'h1000;
    localparam logic [15:0] C_IO  = 16'h0800;
    localparam logic [15:0] C_II  = 16'h0400;
    localparam logic [15:0] C_AI  = 16'h0200;
    localparam logic [15:0] C_AO  = 16'h0100;
    localparam logic [15:0] C_EO  = 16'h0080;
    localparam logic [15:0] C_SU  = 16'h0040;
    localparam logic [15:0] C_BI  = 16'h0020;
    localparam logic [15:0] C_OI  = 16'h0010;
    localparam logic [15:0] C_CE  = 16'h0008;
    localparam logic [15:0] C_CO  = 16'h0004;
    localparam logic [15:0] C_J   = 16'h0002;
    localparam logic [15:0] C_FI  = 16'h0001;

    localparam int M_SYNC = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    typedef struct {
        logic [3:0]  instr;
        bit          fc;
        bit          fz;
        int          len;
        logic [15:0] s2;
        logic [15:0] s3;
        logic [15:0] s4;
    } vec_t;

    logic Clk  = 1'b0;
    logic RstN = 1'b0;
    always #5 Clk = ~Clk;

    control_sequencer_if #(.OPC_W(4), .CTRL_W(16)) bus ();

    control_sequencer #(.OPC_W(4), .CTRL_W(16)) dut (
        .Clk  (Clk),
        .RstN (RstN),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [3:0]  d_instr;
    bit          d_fc, d_fz, d_start, d_force;
    logic [2:0]  d_fval;
    logic [2:0]  cnt;

    int          m_mode;
    logic [3:0]  m_opc;
    bit          m_fault;
    logic [15:0] ucode [16][5];
    int          ulen  [16];

    logic [15:0] last_ctrl;
    logic        last_scr;
    logic [2:0]  last_step;
    logic [15:0] v_exp;
    vec_t        vecs [13];

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs at the falling edge, compare against the model, then advance it.
    task automatic run_cycle();
        logic [15:0] e_ctrl;
        logic        e_scr;
        int          st;
        @(negedge Clk);
        bus.Step    = d_force ? d_fval : cnt;
        bus.InstrIn = d_instr;
        bus.FlagC   = d_fc;
        bus.FlagZ   = d_fz;
        bus.Start   = d_start;
        #1;
        st     = int'(bus.Step);
        e_ctrl = 16'h0000;
        e_scr  = 1'b1;
        if (m_mode == M_RUN && st < ulen[m_opc]) begin
            e_ctrl = ucode[m_opc][st];
            if (st == 2 && ((m_opc == 4'd7 && !d_fc) || (m_opc == 4'd8 && !d_fz)))
                e_ctrl = 16'h0000;
            e_scr = (st == ulen[m_opc] - 1);
        end
        check("ctrl",   bus.Ctrl, e_ctrl);
        check("scr",    16'(bus.StepCounterReset), 16'(e_scr));
        check("halted", 16'(bus.Halted), 16'(m_mode == M_HALT));
        check("fault",  16'(bus.Fault), 16'(m_fault));
        check("opcode", 16'(bus.Opcode), 16'(m_opc));
        last_ctrl = bus.Ctrl;
        last_scr  = bus.StepCounterReset;
        last_step = bus.Step;
        case (m_mode)
            M_SYNC: m_mode = M_RUN;
            M_HALT: if (d_start) m_mode = M_RUN;
            default: begin
                if (st >= ulen[m_opc]) m_fault = 1'b1;
                else if (st == 1) m_opc = d_instr;
                else if (st == 2 && m_opc == 4'd15) m_mode = M_HALT;
            end
        endcase
        cnt = bus.StepCounterReset ? 3'd0 : cnt + 3'd1;
    endtask

    task automatic do_reset(input bit at_neg);
        if (at_neg) @(negedge Clk);
        RstN = 1'b0;
        #1;
        check("rst_ctrl",   bus.Ctrl, 16'h0000);
        check("rst_scr",    16'(bus.StepCounterReset), 16'h0001);
        check("rst_opcode", 16'(bus.Opcode), 16'h0000);
        check("rst_halted", 16'(bus.Halted), 16'h0000);
        check("rst_fault",  16'(bus.Fault), 16'h0000);
        m_mode  = M_SYNC;
        m_opc   = 4'd0;
        m_fault = 1'b0;
        cnt     = 3'd0;
        @(posedge Clk);
        #2;
        RstN = 1'b1;
    endtask

    initial begin
        for (int o = 0; o < 16; o++) begin
            ulen[o]     = 3;
            ucode[o][0] = C_CO | C_MI;
            ucode[o][1] = C_RO | C_II | C_CE;
            for (int s = 2; s < 5; s++) ucode[o][s] = 16'h0000;
        end
        ulen[1] = 4; ucode[1][2] = C_IO | C_MI; ucode[1][3] = C_RO | C_AI;
        ulen[2] = 5; ucode[2][2] = C_IO | C_MI; ucode[2][3] = C_RO | C_BI; ucode[2][4] = C_EO | C_AI | C_FI;
        ulen[3] = 5; ucode[3][2] = C_IO | C_MI; ucode[3][3] = C_RO | C_BI; ucode[3][4] = C_EO | C_AI | C_SU | C_FI;
        ulen[4] = 4; ucode[4][2] = C_IO | C_MI; ucode[4][3] = C_AO | C_RI;
        ucode[5][2]  = C_IO | C_AI;
        ucode[6][2]  = C_IO | C_J;
        ucode[7][2]  = C_IO | C_J;
        ucode[8][2]  = C_IO | C_J;
        ucode[14][2] = C_AO | C_OI;
        ucode[15][2] = C_HLT;

        vecs[0]  = '{4'd0,  1'b0, 1'b0, 3, 16'h0000,      16'h0000,    16'h0000};
        vecs[1]  = '{4'd1,  1'b0, 1'b0, 4, C_IO | C_MI,   C_RO | C_AI, 16'h0000};
        vecs[2]  = '{4'd2,  1'b0, 1'b0, 5, C_IO | C_MI,   C_RO | C_BI, C_EO | C_AI | C_FI};
        vecs[3]  = '{4'd3,  1'b1, 1'b0, 5, C_IO | C_MI,   C_RO | C_BI, C_EO | C_AI | C_SU | C_FI};
        vecs[4]  = '{4'd4,  1'b0, 1'b0, 4, C_IO | C_MI,   C_AO | C_RI, 16'h0000};
        vecs[5]  = '{4'd5,  1'b0, 1'b0, 3, C_IO | C_AI,   16'h0000,    16'h0000};
        vecs[6]  = '{4'd6,  1'b0, 1'b0, 3, C_IO | C_J,    16'h0000,    16'h0000};
        vecs[7]  = '{4'd7,  1'b0, 1'b1, 3, 16'h0000,      16'h0000,    16'h0000};
        vecs[8]  = '{4'd7,  1'b1, 1'b0, 3, C_IO | C_J,    16'h0000,    16'h0000};
        vecs[9]  = '{4'd8,  1'b1, 1'b0, 3, 16'h0000,      16'h0000,    16'h0000};
        vecs[10] = '{4'd8,  1'b0, 1'b1, 3, C_IO | C_J,    16'h0000,    16'h0000};
        vecs[11] = '{4'd14, 1'b0, 1'b0, 3, C_AO | C_OI,   16'h0000,    16'h0000};
        vecs[12] = '{4'd10, 1'b1, 1'b1, 3, 16'h0000,      16'h0000,    16'h0000};

        d_instr = 4'd0; d_fc = 1'b0; d_fz = 1'b0; d_start = 1'b0; d_force = 1'b0; d_fval = 3'd0;
        bus.Step = 3'd0; bus.InstrIn = 4'd0; bus.FlagC = 1'b0; bus.FlagZ = 1'b0; bus.Start = 1'b0;

        // Reset release: one SYNC cycle, then fetch from step 0.
        do_reset(1'b1);
        run_cycle();
        check("sync_ctrl", last_ctrl, 16'h0000);
        check("sync_scr",  16'(last_scr), 16'h0001);

        foreach (vecs[i]) begin
            d_instr = vecs[i].instr;
            d_fc    = vecs[i].fc;
            d_fz    = vecs[i].fz;
            for (int s = 0; s < vecs[i].len; s++) begin
                run_cycle();
                case (s)
                    0:       v_exp = C_CO | C_MI;
                    1:       v_exp = C_RO | C_II | C_CE;
                    2:       v_exp = vecs[i].s2;
                    3:       v_exp = vecs[i].s3;
                    default: v_exp = vecs[i].s4;
                endcase
                check("vec_step", 16'(last_step), 16'(s));
                check("vec_ctrl", last_ctrl, v_exp);
                check("vec_end",  16'(last_scr), 16'(s == vecs[i].len - 1));
            end
        end

        // HLT with Start already high on the entering edge, then ten idle cycles.
        d_instr = 4'd15;
        run_cycle();
        run_cycle();
        d_start = 1'b1;
        run_cycle();
        check("hlt_bit", last_ctrl, C_HLT);
        d_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            run_cycle();
            check("halt_ctrl", last_ctrl, 16'h0000);
            check("halt_flag", 16'(bus.Halted), 16'h0001);
        end
        d_start = 1'b1;
        run_cycle();
        d_start = 1'b0;
        d_instr = 4'd0;
        run_cycle();
        check("resume_ctrl", last_ctrl, C_CO | C_MI);
        check("resume_halt", 16'(bus.Halted), 16'h0000);
        run_cycle();
        run_cycle();

        // Illegal step, sticky fault, cleared only by reset.
        d_force = 1'b1;
        d_fval  = 3'd6;
        run_cycle();
        check("ill_ctrl", last_ctrl, 16'h0000);
        check("ill_scr",  16'(last_scr), 16'h0001);
        d_force = 1'b0;
        d_instr = 4'd5;
        for (int k = 0; k < 3; k++) run_cycle();
        check("fault_sticky", 16'(bus.Fault), 16'h0001);
        do_reset(1'b1);
        run_cycle();

        // Reset asserted mid-cycle during ADD step 3.
        d_instr = 4'd2;
        for (int k = 0; k < 4; k++) run_cycle();
        check("mid_step", 16'(last_step), 16'h0003);
        check("mid_ctrl", last_ctrl, C_RO | C_BI);
        do_reset(1'b0);
        run_cycle();
        for (int k = 0; k < 5; k++) run_cycle();
        check("mid_restart_end", last_ctrl, C_EO | C_AI | C_FI);

        for (int k = 0; k < 400; k++) begin
            d_instr = 4'($urandom_range(0, 15));
            d_fc    = 1'($urandom_range(0, 1));
            d_fz    = 1'($urandom_range(0, 1));
            d_start = ($urandom_range(0, 3) == 0);
            d_force = ($urandom_range(0, 49) == 0);
            d_fval  = 3'($urandom_range(0, 7));
            run_cycle();
        end
        d_force = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
